// File: rtl/codec_cfg_pkg.sv
// Shared types and constants for the codec configuration sequencer:
// FSM encoding, message geometry and the power-up register table.
package codec_cfg_pkg;

  localparam int REG_ADDR_W     = 7;
  localparam int REG_DATA_W     = 9;
  localparam int MSG_W          = REG_ADDR_W + REG_DATA_W;
  localparam int STEP_W         = 4;
  localparam int TMR_W          = 8;
  localparam int INIT_TABLE_LEN = 9;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_STROBE,
    ST_WAIT,
    ST_GAP
  } cfg_state_t;

  typedef logic [MSG_W-1:0] cfg_msg_t;

  // Reset, power, analog path, digital path, I2S format, sampling,
  // left/right headphone volume, active.
  localparam cfg_msg_t INIT_TABLE [INIT_TABLE_LEN] = '{
    16'h1E00, 16'h0C00, 16'h0812, 16'h0A00, 16'h0E02,
    16'h1000, 16'h0579, 16'h0779, 16'h1201
  };

  // Out-of-range indices return an all-zero message instead of X.
  function automatic cfg_msg_t init_entry(input logic [STEP_W-1:0] idx);
    cfg_msg_t entry;
    entry = '0;
    for (int i = 0; i < INIT_TABLE_LEN; i++) begin
      if (idx == STEP_W'(i)) entry = INIT_TABLE[i];
    end
    return entry;
  endfunction

endpackage

// File: rtl/cfg_delay_timer.sv
// Loadable down-counter used to time the STROBE, WAIT and GAP phases.
// A load of N-1 makes zero assert after N cycles in the phase.
module cfg_delay_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/codec_config_sequencer.sv
// Drives the codec's I2C master: walks the init register table after reset
// or START, then serves single runtime writes once initialisation is done.
module codec_config_sequencer
  import codec_cfg_pkg::*;
#(
  parameter int NUM_REGS      = 9,
  parameter int STROBE_CYCLES = 2,
  parameter int XFER_CYCLES   = 70,
  parameter int GAP_CYCLES    = 8,
  parameter bit AUTO_START    = 1'b1
) (
  input  logic              CLOCK50M,
  input  logic              RESET,
  input  logic              START,
  input  logic              WR_REQ,
  input  logic [MSG_W-1:0]  WR_DATA,
  output logic              WR_ACK,
  output logic              InitialiseTransfer,
  output logic [MSG_W-1:0]  message,
  output logic              BUSY,
  output logic              INIT_DONE,
  output logic [STEP_W-1:0] STEP
);

  localparam logic [TMR_W-1:0]  STROBE_VAL = TMR_W'(STROBE_CYCLES - 1);
  localparam logic [TMR_W-1:0]  XFER_VAL   = TMR_W'(XFER_CYCLES - 1);
  localparam logic [TMR_W-1:0]  GAP_VAL    = TMR_W'(GAP_CYCLES - 1);
  localparam logic [STEP_W-1:0] LAST_STEP  = STEP_W'(NUM_REGS - 1);

  cfg_state_t         state, state_d;
  logic               auto_pending;
  logic               runtime, runtime_d;
  logic               take_table, take_wr, gap_done;
  logic               tmr_load, tmr_zero;
  logic [TMR_W-1:0]   tmr_val;
  logic               strobe_d, busy_d, ack_d, done_d;
  logic [STEP_W-1:0]  step_d;
  logic [MSG_W-1:0]   msg_d;

  cfg_delay_timer #(.W(TMR_W)) u_timer (
    .clk      (CLOCK50M),
    .rst_n    (RESET),
    .load     (tmr_load),
    .load_val (tmr_val),
    .en       (state != ST_IDLE),
    .zero     (tmr_zero)
  );

  // auto_pending is a one-shot that fires the table on the first cycle out of reset
  always_ff @(posedge CLOCK50M or negedge RESET) begin
    if (!RESET) begin
      state        <= ST_IDLE;
      auto_pending <= AUTO_START;
    end else begin
      state        <= state_d;
      auto_pending <= 1'b0;
    end
  end

  assign gap_done = (state == ST_GAP) && tmr_zero;

  always_comb begin
    state_d    = state;
    tmr_load   = 1'b0;
    tmr_val    = '0;
    take_table = 1'b0;
    take_wr    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (auto_pending || START) begin
          state_d    = ST_LOAD;
          take_table = 1'b1;
        end else if (INIT_DONE && WR_REQ) begin
          state_d = ST_LOAD;
          take_wr = 1'b1;
        end
      end
      ST_LOAD: begin
        state_d  = ST_STROBE;
        tmr_load = 1'b1;
        tmr_val  = STROBE_VAL;
      end
      ST_STROBE: begin
        if (tmr_zero) begin
          state_d  = ST_WAIT;
          tmr_load = 1'b1;
          tmr_val  = XFER_VAL;
        end
      end
      ST_WAIT: begin
        if (tmr_zero) begin
          state_d  = ST_GAP;
          tmr_load = 1'b1;
          tmr_val  = GAP_VAL;
        end
      end
      ST_GAP: begin
        if (tmr_zero) begin
          state_d = (runtime || (STEP == LAST_STEP)) ? ST_IDLE : ST_LOAD;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Next values for the registered outputs; message only changes on entry to LOAD
  always_comb begin
    strobe_d  = (state_d == ST_STROBE);
    busy_d    = (state_d != ST_IDLE);
    ack_d     = 1'b0;
    done_d    = INIT_DONE;
    step_d    = STEP;
    msg_d     = message;
    runtime_d = runtime;
    if (take_table) begin
      done_d    = 1'b0;
      step_d    = '0;
      msg_d     = init_entry('0);
      runtime_d = 1'b0;
    end else if (take_wr) begin
      ack_d     = 1'b1;
      msg_d     = WR_DATA;
      runtime_d = 1'b1;
    end else if (gap_done && !runtime) begin
      if (STEP == LAST_STEP) begin
        done_d = 1'b1;
      end else begin
        step_d = STEP + STEP_W'(1);
        msg_d  = init_entry(STEP + STEP_W'(1));
      end
    end
  end

  always_ff @(posedge CLOCK50M or negedge RESET) begin
    if (!RESET) begin
      InitialiseTransfer <= 1'b0;
      BUSY               <= 1'b0;
      WR_ACK             <= 1'b0;
      INIT_DONE          <= 1'b0;
      STEP               <= '0;
      message            <= '0;
      runtime            <= 1'b0;
    end else begin
      InitialiseTransfer <= strobe_d;
      BUSY               <= busy_d;
      WR_ACK             <= ack_d;
      INIT_DONE          <= done_d;
      STEP               <= step_d;
      message            <= msg_d;
      runtime            <= runtime_d;
    end
  end

endmodule

// File: tb/tb_codec_config_sequencer.sv
// Bench for codec_config_sequencer: vector table, randomized runtime/START
// operations against a transfer-list model, and reset/START corner cases.
module tb_codec_config_sequencer;

  localparam int XFER_LEN  = 81;
  localparam int NREGS     = 9;
  localparam int OP_BUDGET = 3000;

  logic        clk = 1'b0;
  logic        RESET = 1'b1;
  logic        START = 1'b0;
  logic        WR_REQ = 1'b0;
  logic [15:0] WR_DATA = 16'h0000;
  logic        WR_ACK, InitialiseTransfer, BUSY, INIT_DONE;
  logic [15:0] message;
  logic [3:0]  STEP;

  always #5 clk = ~clk;

  codec_config_sequencer dut (
    .CLOCK50M           (clk),
    .RESET              (RESET),
    .START              (START),
    .WR_REQ             (WR_REQ),
    .WR_DATA            (WR_DATA),
    .WR_ACK             (WR_ACK),
    .InitialiseTransfer (InitialiseTransfer),
    .message            (message),
    .BUSY               (BUSY),
    .INIT_DONE          (INIT_DONE),
    .STEP               (STEP)
  );

  logic [15:0] ref_table [NREGS] = '{
    16'h1E00, 16'h0C00, 16'h0812, 16'h0A00, 16'h0E02,
    16'h1000, 16'h0579, 16'h0779, 16'h1201
  };

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Transfer monitor: records each strobe's message and cycle, checks strobe
  // width and that message only moves on the cycle before a strobe.
  logic [15:0] cap_q [$];
  int          cap_t [$];
  int          cyc = 0;
  logic        prev_strobe = 1'b0;
  logic [15:0] prev_msg = 16'h0000;
  bit          pend = 1'b0;
  int          width = 0;

  always @(negedge clk) begin
    cyc++;
    if (!RESET) begin
      prev_strobe = 1'b0;
      prev_msg    = message;
      pend        = 1'b0;
      width       = 0;
    end else begin
      if (pend) begin
        check("msg_change_only_at_load", 32'(InitialiseTransfer && !prev_strobe), 32'd1);
        pend = 1'b0;
      end
      if (message !== prev_msg) pend = 1'b1;
      if (InitialiseTransfer && !prev_strobe) begin
        cap_q.push_back(message);
        cap_t.push_back(cyc);
        check("msg_stable_load_to_strobe", 32'(message), 32'(prev_msg));
      end
      if (InitialiseTransfer) begin
        width++;
        check("strobe_only_when_busy", 32'(BUSY), 32'd1);
      end else if (prev_strobe) begin
        check("strobe_width", 32'(width), 32'd2);
        width = 0;
      end
      if (WR_ACK) check("ack_only_after_init", 32'(INIT_DONE), 32'd1);
      prev_strobe = InitialiseTransfer;
      prev_msg    = message;
    end
  end

  int          op_busy, op_acks, op_first_busy, op_done_at, op_ack_at;
  logic [15:0] op_first_msg;
  logic        op_first_done;
  logic [3:0]  op_first_step;

  // Drives one operation from a negedge and runs until the DUT is idle with no request pending.
  task automatic run_op(input bit st, input bit wr, input logic [15:0] d);
    bit   fin;
    logic prev_done;
    op_busy = 0; op_acks = 0; op_first_busy = -1; op_done_at = -1; op_ack_at = -1;
    cap_q.delete();
    cap_t.delete();
    @(negedge clk);
    RESET = 1'b1; START = st; WR_REQ = wr; WR_DATA = d;
    prev_done = INIT_DONE;
    fin = 1'b0;
    for (int c = 0; c < OP_BUDGET && !fin; c++) begin
      @(posedge clk);
      #1;
      if (c == 0) begin
        START = 1'b0;
        op_first_msg = message; op_first_done = INIT_DONE; op_first_step = STEP;
      end
      if (BUSY) begin
        op_busy++;
        if (op_first_busy < 0) op_first_busy = c;
      end
      if (INIT_DONE && !prev_done && op_done_at < 0) op_done_at = c;
      prev_done = INIT_DONE;
      if (WR_ACK) begin
        op_acks++;
        if (op_ack_at < 0) op_ack_at = c;
        WR_REQ = 1'b0;
      end
      if (!BUSY && !WR_REQ) fin = 1'b1;
    end
    check("op_finished_in_budget", 32'(fin), 32'd1);
  endtask

  typedef struct {
    bit          st;
    bit          wr;
    logic [15:0] d;
    int          exp_xfers;
    int          exp_acks;
    logic [15:0] exp_first_msg;
    logic        exp_first_done;
    logic [3:0]  exp_first_step;
    logic [15:0] exp_last_msg;
  } vec_t;

  vec_t        vecs [4];
  logic [15:0] exp_q [$];
  bit          fin, hit, seen, r_st, r_wr;
  logic [15:0] r_d;

  initial begin
    vecs[0] = '{1'b0, 1'b1, 16'h0560, 1,  1, 16'h0560, 1'b1, 4'd8, 16'h0560};
    vecs[1] = '{1'b1, 1'b1, 16'h0560, 10, 1, 16'h1E00, 1'b0, 4'd0, 16'h0560};
    vecs[2] = '{1'b1, 1'b0, 16'hABCD, 9,  0, 16'h1E00, 1'b0, 4'd0, 16'h1201};
    vecs[3] = '{1'b0, 1'b1, 16'hFFFF, 1,  1, 16'hFFFF, 1'b1, 4'd8, 16'hFFFF};

    // Reset state
    #1 RESET = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_strobe", 32'(InitialiseTransfer), 32'd0);
    check("rst_busy",   32'(BUSY),      32'd0);
    check("rst_ack",    32'(WR_ACK),    32'd0);
    check("rst_done",   32'(INIT_DONE), 32'd0);
    check("rst_step",   32'(STEP),      32'd0);
    check("rst_msg",    32'(message),   32'd0);

    // Auto-start on release, with a runtime write held pending during init
    run_op(1'b0, 1'b1, 16'h0560);
    check("init_xfer_count", 32'(cap_q.size()), 32'd10);
    for (int i = 0; i < NREGS && i < cap_q.size(); i++)
      check("init_table_order", 32'(cap_q[i]), 32'(ref_table[i]));
    for (int i = 1; i < NREGS && i < cap_t.size(); i++)
      check("init_spacing", 32'(cap_t[i] - cap_t[i-1]), 32'(XFER_LEN));
    if (cap_q.size() > NREGS) check("pending_wr_msg", 32'(cap_q[NREGS]), 32'h0560);
    check("init_done_latency", 32'(op_done_at - op_first_busy), 32'(NREGS * XFER_LEN));
    check("pending_ack_after_done", 32'(op_ack_at), 32'(op_done_at + 1));
    check("pending_ack_count", 32'(op_acks), 32'd1);
    check("init_plus_wr_busy", 32'(op_busy), 32'((NREGS + 1) * XFER_LEN));
    check("init_end_step", 32'(STEP), 32'd8);

    // Vector table
    for (int v = 0; v < 4; v++) begin
      run_op(vecs[v].st, vecs[v].wr, vecs[v].d);
      check("vec_xfers",      32'(cap_q.size()), 32'(vecs[v].exp_xfers));
      check("vec_acks",       32'(op_acks),      32'(vecs[v].exp_acks));
      check("vec_first_msg",  32'(op_first_msg), 32'(vecs[v].exp_first_msg));
      check("vec_first_done", 32'(op_first_done), 32'(vecs[v].exp_first_done));
      check("vec_first_step", 32'(op_first_step), 32'(vecs[v].exp_first_step));
      if (cap_q.size() > 0)
        check("vec_last_msg", 32'(cap_q[cap_q.size()-1]), 32'(vecs[v].exp_last_msg));
      check("vec_busy", 32'(op_busy), 32'(vecs[v].exp_xfers * XFER_LEN));
      if (vecs[v].st && vecs[v].wr)
        check("vec_ack_after_rerun", 32'(op_ack_at), 32'(op_done_at + 1));
    end

    // Randomized operations against a transfer-list model
    for (int it = 0; it < 8; it++) begin
      r_st = ($urandom_range(0, 3) == 0);
      r_wr = r_st ? 1'($urandom_range(0, 1)) : 1'b1;
      r_d  = 16'($urandom);
      exp_q.delete();
      if (r_st) for (int i = 0; i < NREGS; i++) exp_q.push_back(ref_table[i]);
      if (r_wr) exp_q.push_back(r_d);
      repeat ($urandom_range(0, 5)) @(negedge clk);
      run_op(r_st, r_wr, r_d);
      check("rnd_xfers", 32'(cap_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++)
        check("rnd_msg", 32'(cap_q[i]), 32'(exp_q[i]));
      check("rnd_busy", 32'(op_busy), 32'(exp_q.size() * XFER_LEN));
      check("rnd_acks", 32'(op_acks), 32'(r_wr));
      check("rnd_done", 32'(INIT_DONE), 32'd1);
      check("rnd_step", 32'(STEP), 32'd8);
    end

    // START pulses while busy are ignored
    cap_q.delete();
    cap_t.delete();
    @(negedge clk) START = 1'b1;
    @(negedge clk) START = 1'b0;
    fin = 1'b0;
    for (int c = 0; c < OP_BUDGET && !fin; c++) begin
      @(negedge clk);
      START = (c == 100 || c == 400);
      if (!BUSY && c > 1) fin = 1'b1;
    end
    START = 1'b0;
    check("busy_start_finished", 32'(fin), 32'd1);
    check("busy_start_xfers", 32'(cap_q.size()), 32'd9);
    check("busy_start_step", 32'(STEP), 32'd8);
    repeat (5) @(negedge clk);
    check("busy_start_no_rerun", 32'(BUSY), 32'd0);

    // Asynchronous reset during the WAIT of step 4
    @(negedge clk) START = 1'b1;
    @(negedge clk) START = 1'b0;
    hit = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < OP_BUDGET && !hit; c++) begin
      @(negedge clk);
      if (STEP == 4'd4 && InitialiseTransfer) seen = 1'b1;
      if (seen && !InitialiseTransfer) hit = 1'b1;
    end
    check("reached_step4_wait", 32'(hit), 32'd1);
    repeat (5) @(negedge clk);
    check("step4_msg", 32'(message), 32'h0E02);
    #2 RESET = 1'b0;
    #1;
    check("midrst_strobe", 32'(InitialiseTransfer), 32'd0);
    check("midrst_busy",   32'(BUSY),      32'd0);
    check("midrst_step",   32'(STEP),      32'd0);
    check("midrst_msg",    32'(message),   32'd0);
    check("midrst_done",   32'(INIT_DONE), 32'd0);
    repeat (3) @(negedge clk);
    run_op(1'b0, 1'b0, 16'h0000);
    check("rerun_xfers", 32'(cap_q.size()), 32'd9);
    if (cap_q.size() > 0) check("rerun_first_msg", 32'(cap_q[0]), 32'h1E00);
    check("rerun_done", 32'(INIT_DONE), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
